blender_panel_ctrl: RTL and testbench
=====================================

Name: blender_panel_ctrl

Overview:
- Front-panel controller that generates the 5-bit Mode code consumed by the 30-speed blender motor FSM.
- Debounces the user buttons and keeps a target speed.
- Ramps the issued speed upward at a limited rate and drops it immediately.
- Issues momentary pulse codes 29/30/31 while the pulse button is held.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed before a debounced level changes.
- RAMP_INTERVAL, 6, clocks between upward speed steps (one 6-state motor frame).
- MAX_SPEED, 28, highest continuous speed code; codes 29..31 are reserved for pulse.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- btn_up  in  1  raw speed-up button, asynchronous.
- btn_down  in  1  raw speed-down button, asynchronous.
- btn_stop  in  1  raw stop button, asynchronous.
- btn_pulse  in  1  raw momentary pulse button, asynchronous.
- pulse_level  in  2  pulse strength select: 0 = disabled, 1 = 33%, 2 = 66%, 3 = 100%.
- mode  out  5  Mode code to the motor FSM, registered.
- target  out  5  current target speed, 0..MAX_SPEED.
- running  out  1  high when mode != 0.
- pulse_active  out  1  high while in PULSE.

Behaviour:
- Reset: mode=0, target=0, cur=0, running=0, pulse_active=0, FSM=IDLE. Sync flops, debounced levels and counters clear to 0. Reset mid-operation gives mode=0 on the next cycle.
- Input path per button: 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized value differs from the debounced level and clears when they match.
  - At count DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - A debounced 0->1 transition produces a 1-cycle event (ev_up, ev_down, ev_stop, ev_pulse).
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Latency: a raw press held steady produces its event DEBOUNCE_CYCLES+2 clocks after the first sampling edge. The mode/target effect is visible 1 clock after the event.
- Target register, evaluated each cycle in priority order:
  - ev_stop: target=0.
  - ev_up and ev_down together: no change.
  - ev_up: target+1, saturating at MAX_SPEED.
  - ev_down: target-1, saturating at 0.
  - In PULSE, ev_up and ev_down are ignored.
- Issued speed cur, 5 bits:
  - If cur > target: cur=target on the next clock (immediate drop), and ramp_cnt clears.
  - If cur < target: ramp_cnt counts 0..RAMP_INTERVAL-1. At RAMP_INTERVAL-1, cur increments by 1 and ramp_cnt clears.
  - If cur == target: ramp_cnt is held at 0.
  - The first upward step occurs RAMP_INTERVAL clocks after target rises.
- FSM states: IDLE, RAMP, HOLD, PULSE.
  - IDLE -> RAMP when target > 0.
  - RAMP -> HOLD when cur == target and target != 0.
  - RAMP -> IDLE when target == 0; cur forced to 0.
  - HOLD -> RAMP when target > cur.
  - HOLD follows immediate drops and stays in HOLD; it goes to IDLE when target becomes 0.
  - Any non-PULSE state -> PULSE on ev_pulse with pulse_level != 0. pulse_level is latched into plvl, and target and cur clear to 0.
  - PULSE -> IDLE when the debounced pulse level falls.
  - ev_pulse with pulse_level == 0 is ignored.
  - pulse_level changes during PULSE are ignored.
  - ev_stop in any state, including PULSE, forces IDLE and clears target and cur. Pulse then requires a fresh press.
  - ev_stop has priority over ev_pulse in the same cycle.
- mode (registered) by state: IDLE = 0; RAMP/HOLD = cur; PULSE = 28 + plvl (29, 30 or 31).
- running = (mode != 0). pulse_active = (state == PULSE).
- mode never exceeds MAX_SPEED outside PULSE. Widths are 5 bits with no wrap; all arithmetic saturates.

Test Plan:
- Reset asserted 3 clocks with buttons idle -> mode=0, target=0, running=0, pulse_active=0. Assert reset mid-ramp at mode=5 -> mode=0 on the next clock.
- Three clean btn_up presses of 8 clocks each -> target=3. mode steps 1, 2, 3 at 6-clock intervals, then holds at 3 (HOLD).
- 32 btn_up presses -> target saturates at 28. mode reaches 28 and never shows 29..31.
- At mode=10, one btn_down press -> mode=9 one clock after ev_down. Then btn_stop -> mode=0 one clock after ev_stop and target=0.
- pulse_level=2, btn_pulse held 20 clocks from mode=7 -> mode=30 and pulse_active=1 while held, target=0. After release and debounce, mode=0. Repeating with pulse_level=0 -> no change.
- 3-clock glitch on btn_up -> no event. btn_up and btn_down debounced in the same cycle -> target unchanged. btn_stop pressed during pulse -> mode=0 with btn_pulse still held.

Source files
------------

// File: rtl/blender_panel_ctrl.sv
// Front-panel controller: debounced buttons, target speed, rate-limited ramp-up
// with immediate drop, and momentary pulse codes for the blender motor FSM.
module blender_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RAMP_INTERVAL   = 6,
  parameter int unsigned MAX_SPEED       = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_stop,
  input  logic       btn_pulse,
  input  logic [1:0] pulse_level,
  output logic [4:0] mode,
  output logic [4:0] target,
  output logic       running,
  output logic       pulse_active
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RW = (RAMP_INTERVAL > 1) ? $clog2(RAMP_INTERVAL) : 1;
  localparam int unsigned NB = 4;
  localparam int unsigned B_UP    = 0;
  localparam int unsigned B_DOWN  = 1;
  localparam int unsigned B_STOP  = 2;
  localparam int unsigned B_PULSE = 3;
  localparam logic [4:0] MAXS = 5'(MAX_SPEED);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD, PULSE} state_t;

  // ---------------- input synchronizers and debouncers ----------------
  logic [NB-1:0] raw, sync1, sync2, deb, ev;
  logic [CW-1:0] dcnt [NB];

  assign raw = {btn_pulse, btn_stop, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      ev    <= '0;
      for (int unsigned i = 0; i < NB; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      ev    <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] != deb[i]) begin
          if (dcnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]  <= sync2[i];
            ev[i]   <= sync2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  logic ev_up, ev_down, ev_stop, ev_pulse;
  assign ev_up    = ev[B_UP];
  assign ev_down  = ev[B_DOWN];
  assign ev_stop  = ev[B_STOP];
  assign ev_pulse = ev[B_PULSE];

  // ---------------- control state ----------------
  state_t         state, state_next;
  logic [4:0]     cur, cur_next, target_next, mode_next;
  logic [RW-1:0]  ramp_cnt, ramp_next;
  logic [1:0]     plvl, plvl_next;
  logic           running_next, pulse_active_next;
  logic           pulse_start;

  assign pulse_start = ev_pulse && !ev_stop && (state != PULSE) && (pulse_level != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      target       <= '0;
      cur          <= '0;
      ramp_cnt     <= '0;
      plvl         <= '0;
      mode         <= '0;
      running      <= 1'b0;
      pulse_active <= 1'b0;
    end else begin
      state        <= state_next;
      target       <= target_next;
      cur          <= cur_next;
      ramp_cnt     <= ramp_next;
      plvl         <= plvl_next;
      mode         <= mode_next;
      running      <= running_next;
      pulse_active <= pulse_active_next;
    end
  end

  always_comb begin
    state_next = state;
    if (ev_stop) begin
      state_next = IDLE;
    end else if (pulse_start) begin
      state_next = PULSE;
    end else begin
      case (state)
        IDLE:    if (target != '0) state_next = RAMP;
        RAMP: begin
          if (target == '0)       state_next = IDLE;
          else if (cur == target) state_next = HOLD;
        end
        HOLD: begin
          if (target == '0)      state_next = IDLE;
          else if (target > cur) state_next = RAMP;
        end
        PULSE:   if (!deb[B_PULSE]) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Drops compare against the next target so they land on the same edge as
  // the event; the ramp counts against the registered target.
  always_comb begin
    target_next = target;
    cur_next    = cur;
    ramp_next   = ramp_cnt;
    plvl_next   = plvl;

    if (ev_stop || pulse_start) begin
      target_next = '0;
    end else if (state != PULSE) begin
      if (ev_up && !ev_down)
        target_next = (target >= MAXS) ? MAXS : target + 5'd1;
      else if (ev_down && !ev_up)
        target_next = (target == '0) ? '0 : target - 5'd1;
    end

    if (ev_stop || pulse_start) begin
      cur_next  = '0;
      ramp_next = '0;
    end else if (cur > target_next) begin
      cur_next  = target_next;
      ramp_next = '0;
    end else if ((cur < target) && (cur < target_next)) begin
      if (ramp_cnt == RW'(RAMP_INTERVAL - 1)) begin
        cur_next  = cur + 5'd1;
        ramp_next = '0;
      end else begin
        ramp_next = ramp_cnt + 1'b1;
      end
    end else begin
      ramp_next = '0;
    end

    if (pulse_start) plvl_next = pulse_level;
  end

  // Outputs are registered from next-state values so mode follows an event by one clock.
  always_comb begin
    mode_next = '0;
    case (state_next)
      IDLE:       mode_next = '0;
      RAMP, HOLD: mode_next = cur_next;
      PULSE:      mode_next = 5'd28 + {3'b000, plvl_next};
      default:    mode_next = '0;
    endcase
    running_next      = (mode_next != '0);
    pulse_active_next = (state_next == PULSE);
  end

endmodule

// File: tb/tb_blender_panel_ctrl.sv
// Directed bench for blender_panel_ctrl: debounce latency, ramp timing,
// saturation, immediate drop, stop, pulse entry/exit and reset behaviour.
module tb_blender_panel_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_stop, btn_pulse;
  logic [1:0] pulse_level;
  logic [4:0] mode, target;
  logic       running, pulse_active;

  int total = 0;
  int bad   = 0;
  int max_mode = 0;

  localparam int UP = 0, DOWN = 1, STOP = 2, PULSEB = 3;

  blender_panel_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RAMP_INTERVAL(6),
    .MAX_SPEED(28)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_stop(btn_stop),
    .btn_pulse(btn_pulse),
    .pulse_level(pulse_level),
    .mode(mode),
    .target(target),
    .running(running),
    .pulse_active(pulse_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (int'(mode) > max_mode) max_mode = int'(mode);
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      UP:      btn_up    = v;
      DOWN:    btn_down  = v;
      STOP:    btn_stop  = v;
      default: btn_pulse = v;
    endcase
  endtask

  task automatic press(input int which, input int hi, input int lo);
    set_btn(which, 1'b1);
    tick(hi);
    set_btn(which, 1'b0);
    tick(lo);
  endtask

  task automatic wait_mode(input string tag, input int val, input int budget);
    int n = 0;
    while (int'(mode) != val && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, int'(mode), val);
  endtask

  // Press for 'hold' clocks and report at which clock target/mode first changed.
  task automatic measure(input int which, input int hold,
                         output int tk, output int mk, output int mv);
    int t0 = int'(target);
    int m0 = int'(mode);
    tk = 0; mk = 0; mv = -1;
    set_btn(which, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (k == hold) set_btn(which, 1'b0);
      if (tk == 0 && int'(target) != t0) tk = k;
      if (mk == 0 && int'(mode) != m0) begin
        mk = k;
        mv = int'(mode);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int tk, mk, mv;
    reset = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_stop = 1'b0; btn_pulse = 1'b0;
    pulse_level = 2'd0;
    tick(3);
    chk("rst_mode", int'(mode), 0);
    chk("rst_target", int'(target), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_pulse_active", int'(pulse_active), 0);
    reset = 1'b0;
    tick(2);

    // three clean up presses: event latency and 6-clock ramp steps
    for (int p = 0; p < 3; p++) begin
      measure(UP, 8, tk, mk, mv);
      chk("up_target_latency", tk, 7);
      chk("up_step_delay", mk - tk, 6);
      chk("up_step_value", mv, p + 1);
    end
    chk("up3_target", int'(target), 3);
    tick(10);
    chk("up3_hold_mode", int'(mode), 3);
    chk("up3_running", int'(running), 1);

    // saturation at MAX_SPEED
    max_mode = 0;
    for (int p = 0; p < 32; p++) press(UP, 8, 8);
    tick(200);
    chk("sat_target", int'(target), 28);
    chk("sat_mode", int'(mode), 28);
    chk("sat_max_mode", max_mode, 28);

    // walk down to 10, then single down and stop
    for (int p = 0; p < 18; p++) press(DOWN, 8, 8);
    tick(5);
    chk("down10_target", int'(target), 10);
    chk("down10_mode", int'(mode), 10);
    measure(DOWN, 8, tk, mk, mv);
    chk("down_target_latency", tk, 7);
    chk("down_mode_latency", mk, 7);
    chk("down_mode_value", mv, 9);
    measure(STOP, 8, tk, mk, mv);
    chk("stop_mode_latency", mk, 7);
    chk("stop_mode_value", mv, 0);
    chk("stop_target", int'(target), 0);

    // reset in the middle of a ramp
    for (int p = 0; p < 5; p++) press(UP, 8, 8);
    wait_mode("pre_reset_reach5", 5, 100);
    btn_up = 1'b1;
    tick(10);
    chk("pre_reset_mode", int'(mode), 5);
    btn_up = 1'b0;
    reset = 1'b1;
    tick(1);
    chk("midrst_mode", int'(mode), 0);
    chk("midrst_target", int'(target), 0);
    reset = 1'b0;
    tick(20);
    chk("post_rst_mode", int'(mode), 0);

    // pulse at level 2 from mode 7; level change while held is ignored
    for (int p = 0; p < 7; p++) press(UP, 8, 8);
    wait_mode("pre_pulse_reach7", 7, 100);
    pulse_level = 2'd2;
    btn_pulse = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (k == 10) pulse_level = 2'd3;
      if (k == 6)  chk("pulse_before_entry", int'(mode), 7);
      if (k == 7) begin
        chk("pulse_mode", int'(mode), 30);
        chk("pulse_active", int'(pulse_active), 1);
        chk("pulse_target", int'(target), 0);
      end
      if (k == 20) begin
        chk("pulse_mode_held", int'(mode), 30);
        btn_pulse = 1'b0;
      end
      if (k == 26) chk("pulse_release_still", int'(mode), 30);
      if (k == 27) begin
        chk("pulse_exit_mode", int'(mode), 0);
        chk("pulse_exit_active", int'(pulse_active), 0);
      end
    end

    // pulse with level 0 is ignored
    press(UP, 8, 8);
    press(UP, 8, 8);
    wait_mode("lvl0_reach2", 2, 100);
    pulse_level = 2'd0;
    btn_pulse = 1'b1;
    tick(12);
    chk("lvl0_mode", int'(mode), 2);
    chk("lvl0_active", int'(pulse_active), 0);
    chk("lvl0_target", int'(target), 2);
    btn_pulse = 1'b0;
    tick(20);

    // 3-clock glitch: no event; 4-clock press: event
    btn_up = 1'b1; tick(3); btn_up = 1'b0; tick(20);
    chk("glitch3_target", int'(target), 2);
    btn_up = 1'b1; tick(4); btn_up = 1'b0; tick(20);
    chk("press4_target", int'(target), 3);

    // up and down in the same cycle cancel
    btn_up = 1'b1; btn_down = 1'b1;
    tick(8);
    btn_up = 1'b0; btn_down = 1'b0;
    tick(20);
    chk("updown_target", int'(target), 3);

    // stop while pulse held; no re-entry without a fresh press
    pulse_level = 2'd3;
    btn_pulse = 1'b1;
    tick(10);
    chk("pulse3_mode", int'(mode), 31);
    chk("pulse3_active", int'(pulse_active), 1);
    btn_stop = 1'b1;
    tick(7);
    chk("stop_in_pulse_mode", int'(mode), 0);
    chk("stop_in_pulse_active", int'(pulse_active), 0);
    btn_stop = 1'b0;
    tick(20);
    chk("no_repulse_mode", int'(mode), 0);
    btn_pulse = 1'b0;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
